bch_correct: RTL
================

// Module: bch_correct
// PURPOSE
//  Receive-side correction stage. Buffers the received data bits of each codeword while
//  syndrome, key and Chien search run. XORs the buffered bits with the serial error-locator
//  stream from bch_error and emits corrected data bits with first/last framing.
//  Sits after bch_error and runs in parallel with bch_syndrome on the input side.
// PARAMETERS
//  P      `BCH_SANE  BCH parameter vector. B = `BCH_DATA_BITS(P) bits per word.
//  DEPTH  4          Words buffered, >=2. Covers syndrome+key+chien pipeline occupancy.
// PORTS
//  clk        in   1             clock
//  reset      in   1             synchronous, active-high
//  in_valid   in   1             data_in carries a received data bit
//  in_first   in   1             qualifies bit 0 of a new word (with in_valid)
//  data_in    in   1             received (uncorrected) data bit, bit 0 first
//  in_ready   out  1             buffer can accept a bit this cycle
//  err_start  in   1             bch_error ready: first error bit (bit 0) on err
//  err_valid  in   1             bch_error valid: subsequent error bits on err
//  err        in   1             error flag for the current bit position
//  out_valid  out  1             data_out valid
//  out_first  out  1             data_out is bit 0 of a word
//  out_last   out  1             data_out is bit B-1 of a word
//  data_out   out  1             corrected bit = stored bit ^ err
//  words      out  log2(DEPTH+1) committed, unread words in the buffer
//  underflow  out  1             sticky: error stream arrived with no committed word
//  proto_err  out  1             sticky: in_first mid-word, or err_valid mid-word gap/overrun
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; wr/rd pointers, bit indices and words cleared.
//  Reset mid-operation discards partial and buffered words; the next word must start with in_first.
//  Storage: DEPTH x B bit array. wr_ptr/rd_ptr wrap modulo DEPTH. Bit index 0..B-1.
//  Write: accept when in_valid && in_ready. in_first forces bit index 0.
//   - Bit B-1 commits the word: wr_ptr++, words++.
//   - in_valid without in_first while idle (index 0, no word open): bit dropped, proto_err set.
//   - in_first while a word is open: partial word discarded, restart at bit 0 of same slot, proto_err set.
//  in_ready = (words < DEPTH). Combinational from registered count; an uncommitted slot is always free.
//  Read FSM: IDLE -> RUN on err_start. RUN stays on err_valid. After bit B-1 -> IDLE.
//  A new err_start in RUN before bit B-1: proto_err set, restart at bit 0 of the same rd slot.
//  No backpressure on read side (bch_error accepted tied 1); every strobe is consumed.
//  Latency: outputs registered, 1 cycle after err_start/err_valid.
//   - Registered outputs: out_valid, out_first (on err_start), out_last (index B-1), data_out.
//  Completing bit B-1 frees the word: rd_ptr++, words--.
//  Same-cycle commit and free: words unchanged; both pointers advance.
//  Underflow: err_start with words==0 sets underflow. Strobes are still emitted with data_out=err.
//   - Pointers and words are not touched.
//  err_valid in IDLE (no err_start): ignored, proto_err set.
//  Sticky flags clear only on reset.
// CONFIGURATION
//  BCH_CORRECT_STATS_EN defined:
//   - Adds output out_flips [log2(B+1)-1:0]: count of err=1 bits in the word.
//   - Valid with out_last, holds until the next out_last, reset 0.
//   - Saturation is impossible by width.
//  Not defined: port absent, no counter logic.
// TESTING (B=16, DEPTH=4)
//  Clean word 0xA5C3 in; err_start + 15 err_valid all err=0
//   -> data_out serial 0xA5C3 LSB first; out_first/out_last on bits 0/15; words 1->0.
//  Same word; err=1 at bits 0,7,15 -> output 0x2542; with STATS_EN, out_flips=3 at out_last.
//  Write 4 words with no reads -> in_ready=0 after 4th commit; 5th in_valid ignored.
//   - One read completes -> in_ready=1 next cycle.
//  err_start with words==0 -> underflow=1, data_out==err, words stays 0; then clean traffic passes.
//  Bit 15 commit and bit 15 free in the same cycle at words=2 -> words stays 2; pointers wrap 3->0 correctly.
//  Reset asserted mid-write and mid-read -> next cycle words=0, out_valid=0, flags 0, in_ready=1.

Source files
------------

// File: rtl/bch_correct_if.sv
// Stream bundle for the BCH receive-side correction stage: raw data input,
// serial error-locator input and corrected data output with status.
// The optional out_flips field exists only when BCH_CORRECT_STATS_EN is defined.
interface bch_correct_if #(
  parameter int DEPTH = 4
`ifdef BCH_CORRECT_STATS_EN
  , parameter int B = 16
`endif
);
  localparam int WW = $clog2(DEPTH + 1);
`ifdef BCH_CORRECT_STATS_EN
  localparam int FW = $clog2(B + 1);
  logic [FW-1:0] out_flips;
`endif

  logic          in_valid;
  logic          in_first;
  logic          data_in;
  logic          in_ready;
  logic          err_start;
  logic          err_valid;
  logic          err;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic          data_out;
  logic [WW-1:0] words;
  logic          underflow;
  logic          proto_err;

  // Upstream/downstream environment view.
  modport master (
`ifdef BCH_CORRECT_STATS_EN
    input  out_flips,
`endif
    output in_valid, in_first, data_in, err_start, err_valid, err,
    input  in_ready, out_valid, out_first, out_last, data_out,
    input  words, underflow, proto_err
  );

  // Correction stage view.
  modport slave (
`ifdef BCH_CORRECT_STATS_EN
    output out_flips,
`endif
    input  in_valid, in_first, data_in, err_start, err_valid, err,
    output in_ready, out_valid, out_first, out_last, data_out,
    output words, underflow, proto_err
  );
endinterface

// File: rtl/bch_correct.sv
// BCH receive-side correction stage.
// Buffers DEPTH received words of B data bits while syndrome/key/Chien run,
// then XORs each buffered bit with the serial error-locator stream and emits
// corrected bits with first/last framing, one cycle after each error strobe.
// Optional feature: define BCH_CORRECT_STATS_EN to add out_flips, the number
// of corrected (err=1) bits in the word just completed.
module bch_correct #(
  parameter int B     = 16,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  bch_correct_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(B);
  localparam int WW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {IDLE, RUN} rd_state_t;

  // Word storage; one row per buffered codeword, bit 0 first.
  logic [B-1:0]  mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [IW-1:0] wr_idx_reg;
  logic          wr_open_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [IW-1:0] rd_idx_reg;
  logic          rd_under_reg;
  rd_state_t     rd_state_reg;
  logic [WW-1:0] words_reg;
  logic          out_valid_reg;
  logic          out_first_reg;
  logic          out_last_reg;
  logic          data_out_reg;
  logic          underflow_reg;
  logic          proto_err_reg;

  logic          in_ready;
  logic          wr_en;
  logic          wr_commit;
  logic          wr_proto;
  logic [IW-1:0] wr_bit;

  logic          rd_strobe;
  logic          rd_last;
  logic          rd_free;
  logic          under_now;
  logic [IW-1:0] rd_bit;
  logic          stored_bit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Space exists whenever fewer than DEPTH words are committed; the slot being
  // filled is never counted, so it is always available.
  assign in_ready = (words_reg < WW'(DEPTH));

  // Decode the write-side action for this cycle.
  always_comb begin
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    wr_proto  = 1'b0;
    wr_bit    = wr_idx_reg;
    if (bus.in_valid && in_ready) begin
      if (bus.in_first) begin
        // A new word always restarts at bit 0 of the current slot.
        wr_en    = 1'b1;
        wr_bit   = '0;
        wr_proto = wr_open_reg;
      end else if (!wr_open_reg) begin
        // Continuation bit with no word open: drop it.
        wr_proto = 1'b1;
      end else begin
        wr_en     = 1'b1;
        wr_commit = (wr_idx_reg == IW'(B - 1));
      end
    end
  end

  // Store accepted data bits into the slot being filled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg][wr_bit] <= bus.data_in;
    end
  end

  // Track the write slot and bit position.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      wr_idx_reg  <= '0;
      wr_open_reg <= 1'b0;
    end else if (wr_en) begin
      if (wr_commit) begin
        wr_ptr_reg  <= ptr_inc(wr_ptr_reg);
        wr_idx_reg  <= '0;
        wr_open_reg <= 1'b0;
      end else begin
        wr_idx_reg  <= wr_bit + IW'(1);
        wr_open_reg <= 1'b1;
      end
    end
  end

  // Decode the read-side action: which bit is corrected and whether a word ends.
  always_comb begin
    rd_bit     = bus.err_start ? '0 : rd_idx_reg;
    rd_strobe  = bus.err_start || (bus.err_valid && (rd_state_reg == RUN));
    // An underflowed word has no backing storage; the error stream passes through.
    under_now  = bus.err_start ? (words_reg == '0) : rd_under_reg;
    stored_bit = mem[rd_ptr_reg][rd_bit] & ~under_now;
    rd_last    = !bus.err_start && bus.err_valid && (rd_state_reg == RUN) &&
                 (rd_idx_reg == IW'(B - 1));
    rd_free    = rd_last && !rd_under_reg;
  end

  // Read FSM, registered outputs, word count and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_reg  <= IDLE;
      rd_ptr_reg    <= '0;
      rd_idx_reg    <= '0;
      rd_under_reg  <= 1'b0;
      words_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_first_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      data_out_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      out_valid_reg <= rd_strobe;
      out_first_reg <= bus.err_start;
      out_last_reg  <= rd_last;
      data_out_reg  <= rd_strobe ? (stored_bit ^ bus.err) : 1'b0;
      words_reg     <= words_reg + WW'(wr_commit) - WW'(rd_free);

      if (wr_proto) begin
        proto_err_reg <= 1'b1;
      end

      if (bus.err_start) begin
        // Start (or restart) the word at the head slot.
        if (rd_state_reg == RUN) begin
          proto_err_reg <= 1'b1;
        end
        if (words_reg == '0) begin
          underflow_reg <= 1'b1;
        end
        rd_state_reg <= RUN;
        rd_idx_reg   <= IW'(1);
        rd_under_reg <= (words_reg == '0);
      end else if (rd_state_reg == RUN) begin
        if (bus.err_valid) begin
          if (rd_last) begin
            rd_state_reg <= IDLE;
            rd_idx_reg   <= '0;
            rd_under_reg <= 1'b0;
            if (!rd_under_reg) begin
              rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
          end else begin
            rd_idx_reg <= rd_idx_reg + IW'(1);
          end
        end else begin
          // The error stream is contiguous within a word; a hole is a protocol fault.
          proto_err_reg <= 1'b1;
        end
      end else if (bus.err_valid) begin
        // Error bit with no word in progress: ignored.
        proto_err_reg <= 1'b1;
      end
    end
  end

`ifdef BCH_CORRECT_STATS_EN
  localparam int FW = $clog2(B + 1);
  logic [FW-1:0] flip_acc_reg;
  logic [FW-1:0] out_flips_reg;

  // Count corrected bits per word; publish the total with out_last.
  always_ff @(posedge clk) begin
    if (reset) begin
      flip_acc_reg  <= '0;
      out_flips_reg <= '0;
    end else if (bus.err_start) begin
      flip_acc_reg <= FW'(bus.err);
    end else if (rd_last) begin
      out_flips_reg <= flip_acc_reg + FW'(bus.err);
      flip_acc_reg  <= '0;
    end else if (rd_strobe) begin
      flip_acc_reg <= flip_acc_reg + FW'(bus.err);
    end
  end

  assign bus.out_flips = out_flips_reg;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_first = out_first_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.data_out  = data_out_reg;
  assign bus.words     = words_reg;
  assign bus.underflow = underflow_reg;
  assign bus.proto_err = proto_err_reg;

endmodule
